// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and transmitter state encoding.
package uart_pkg;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_DEFAULT_DIV = 434;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; full/empty are derived from the count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped even if a pop happens on the same edge.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage has no reset; stale entries are never read because empty gates pops.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO drained back-to-back onto uart_txd.
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit (low) for CLK_DIV cycles
// DATA  | eight data bits, LSB first, CLK_DIV cycles each
// STOP  | stop bit (high); pops the next byte straight into START if one is waiting
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = UART_DEFAULT_DIV,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             uart_txd,
    output logic             tx_busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(UART_DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(UART_DATA_BITS - 1);

    tx_state_t                 state_q, state_d;
    logic [BAUD_W-1:0]         baud_q, baud_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      txd_q, txd_d;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_pop;
    logic [7:0]                fifo_head;
    logic                      baud_done;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (in_valid & in_ready),
        .push_data_i (in_data),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign in_ready  = ~fifo_full;
    assign tx_busy   = (state_q != IDLE) | ~fifo_empty;
    assign uart_txd  = txd_q;
    assign baud_done = (baud_q == '0);

    // Next-state, counters and shift register; the pin value is computed from the
    // next state so the flop presents each bit in the same cycle the state enters it.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    bit_d    = '0;
                    baud_d   = BAUD_RELOAD;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = BAUD_RELOAD;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = BAUD_RELOAD;
                    shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == LAST_BIT) state_d = STOP;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        bit_d    = '0;
                        baud_d   = BAUD_RELOAD;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset drives the line high immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo with CLK_DIV=4, FIFO_DEPTH=4.
module tb_uart_tx_fifo;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       uart_txd;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_acc = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    logic       mon_active = 1'b0;
    logic       mon_skip = 1'b0;
    logic       mon_bad = 1'b0;
    int         mon_k = 0;
    int         mon_bad_k = 0;
    logic       mon_bad_v = 1'b0;
    logic [7:0] mon_byte = 8'h00;
    logic [9:0] mon_frame = 10'h3FF;

    uart_tx_fifo #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic to_cyc(input int c);
        if (cyc > c) begin
            tests++;
            fails++;
            $display("FAIL schedule: already at cycle %0d, required %0d", cyc, c);
        end
        while (cyc < c) @(negedge clk);
    endtask

    // Drive a byte and hold until accepted; returns at the negedge after acceptance.
    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: byte %02h not accepted after %0d cycles", b, n);
        end else begin
            exp_q.push_back(b);
            last_acc = cyc + 1;
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((tx_busy || mon_active) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(n < 2000), 1);
    endtask

    // Frame monitor: on each start bit pop the expected byte and check every cycle of the frame.
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && uart_txd === 1'b0) begin
                mon_active = 1'b1;
                mon_k      = 0;
                mon_bad    = 1'b0;
                start_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    mon_skip = 1'b1;
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
                end else begin
                    mon_skip  = 1'b0;
                    mon_byte  = exp_q.pop_front();
                    mon_frame = {1'b1, mon_byte, 1'b0};
                end
            end
            if (mon_active) begin
                if (!mon_skip && !mon_bad && uart_txd !== mon_frame[mon_k / DIV]) begin
                    mon_bad   = 1'b1;
                    mon_bad_k = mon_k;
                    mon_bad_v = uart_txd;
                end
                mon_k++;
                if (mon_k == 10 * DIV) begin
                    mon_active = 1'b0;
                    if (!mon_skip) begin
                        tests++;
                        if (mon_bad) begin
                            fails++;
                            $display("FAIL frame_%02h: frame cycle %0d read %b, required %b",
                                     mon_byte, mon_bad_k, mon_bad_v, mon_frame[mon_bad_k / DIV]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int a;
        logic [9:0] pat;

        // Reset held: outputs at their idle values
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_txd", int'(uart_txd), 1);
            chk("rst_ready", int'(in_ready), 1);
            chk("rst_busy", int'(tx_busy), 0);
            chk("rst_count", int'(fifo_count), 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0xA5: line reads 0,1,0,1,0,0,1,0,1,1 every 4 cycles
        start_q.delete();
        pat = 10'b11_0100_1010;
        push_byte(8'hA5);
        a = last_acc;
        in_valid = 1'b0;
        chk("a5_count_after_push", int'(fifo_count), 1);
        chk("a5_busy_after_push", int'(tx_busy), 1);
        for (int k = 0; k < 10; k++) begin
            to_cyc(a + 1 + 4 * k);
            chk($sformatf("a5_bit%0d", k), int'(uart_txd), int'(pat[k]));
            if (k == 0) chk("a5_count_after_pop", int'(fifo_count), 0);
        end
        to_cyc(a + 40);
        chk("a5_busy_last", int'(tx_busy), 1);
        to_cyc(a + 41);
        chk("a5_busy_drop", int'(tx_busy), 0);
        chk("a5_txd_idle", int'(uart_txd), 1);
        wait_idle();
        chk("a5_frames", start_q.size(), 1);
        if (start_q.size() == 1) chk("a5_latency", start_q[0], a + 1);

        // Back-to-back 0x00 then 0xFF on consecutive cycles
        start_q.delete();
        push_byte(8'h00);
        a = last_acc;
        push_byte(8'hFF);
        in_valid = 1'b0;
        chk("b2b_second_acc", last_acc, a + 1);
        to_cyc(a + 80);
        chk("b2b_busy_last", int'(tx_busy), 1);
        to_cyc(a + 81);
        chk("b2b_busy_drop", int'(tx_busy), 0);
        wait_idle();
        chk("b2b_frames", start_q.size(), 2);
        if (start_q.size() == 2) begin
            chk("b2b_first_start", start_q[0], a + 1);
            chk("b2b_gap", start_q[1] - start_q[0], 40);
        end

        // Fill: 0x01..0x05 with in_valid held, then a stalled 6th push
        for (int i = 1; i <= 5; i++) begin
            push_byte(8'(i));
            if (i == 1) a = last_acc;
        end
        chk("fill_ready_low", int'(in_ready), 0);
        chk("fill_count_full", int'(fifo_count), 4);
        chk("fill_busy", int'(tx_busy), 1);
        push_byte(8'h06);
        in_valid = 1'b0;
        chk("fill_stall_acc", last_acc, a + 42);
        wait_idle();

        // Push and pop on the same edge at fifo_count=2
        push_byte(8'h11);
        a = last_acc;
        push_byte(8'h22);
        push_byte(8'h33);
        in_valid = 1'b0;
        to_cyc(a + 40);
        chk("pp_count_before", int'(fifo_count), 2);
        push_byte(8'h44);
        in_valid = 1'b0;
        chk("pp_acc", last_acc, a + 41);
        chk("pp_count_after", int'(fifo_count), 2);
        wait_idle();

        // Reset during data bit 3 of 0x3C with two bytes queued
        push_byte(8'h3C);
        a = last_acc;
        push_byte(8'h81);
        push_byte(8'h7E);
        in_valid = 1'b0;
        to_cyc(a + 18);
        chk("mid_count", int'(fifo_count), 2);
        chk("mid_busy", int'(tx_busy), 1);
        rst = 1'b1;
        #1;
        chk("arst_txd", int'(uart_txd), 1);
        chk("arst_count", int'(fifo_count), 0);
        chk("arst_ready", int'(in_ready), 1);
        chk("arst_busy", int'(tx_busy), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_idle_txd", int'(uart_txd), 1);
            chk("post_rst_idle_busy", int'(tx_busy), 0);
        end
        start_q.delete();
        push_byte(8'h55);
        a = last_acc;
        in_valid = 1'b0;
        wait_idle();
        chk("post_rst_frames", start_q.size(), 1);
        if (start_q.size() == 1) chk("post_rst_latency", start_q[0], a + 1);

        repeat (4) @(negedge clk);
        chk("leftover_expected", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
